mach_ram_bridge: RTL and testbench
==================================

Name: mach_ram_bridge

Overview:
- Sits between the machine's RAM-side bus (32-bit V810 data port: address, data-in, chip enable, RW, byte enables, ready) and a 16-bit external memory port with a level request/acknowledge handshake, e.g. an SDRAM or BRAM controller.
- Splits each 32-bit RAM bus cycle into one or two 16-bit memory transactions, skipping any half whose byte enables are all inactive.
- Assembles read data and drives RAM_READYn back to the bus.

Parameters:
- ADDR_W, 21: byte-address width of RAM_A; the memory word address is ADDR_W-1 bits.
- WAIT_CE, 0: extra CE cycles inserted before RAM_READYn asserts, for timing experiments (0..15).

Ports:
- CLK  in  1  system clock; single clock domain.
- RES  in  1  reset, asynchronous, active-high.
- CE  in  1  CPU clock enable; all bus-side sampling is qualified by CE.
- BCYSTn  in  1  bus cycle start from the CPU memory unit, active low.
- RAM_A  in  ADDR_W  byte address.
- RAM_DI  in  32  write data.
- RAM_DO  out  32  read data.
- RAM_CEn  in  1  RAM select, active low.
- RAM_WEn  in  1  RW: 1 = read, 0 = write.
- RAM_BEn  in  4  byte enables, active low; bit n covers RAM_DI[8n+7:8n].
- RAM_READYn  out  1  cycle complete, active low.
- MEM_A  out  ADDR_W-1  16-bit word address.
- MEM_D  out  16  write data.
- MEM_Q  in  16  read data; valid on the cycle MEM_ACK=1.
- MEM_BEn  out  2  byte enables, active low.
- MEM_WE  out  1  1 = write.
- MEM_REQ  out  1  request; level signal.
- MEM_ACK  in  1  one-CLK acknowledge pulse.

Behaviour:
- Reset values: state IDLE, RAM_DO=0, RAM_READYn=1, MEM_REQ=0, MEM_WE=0, MEM_A=0, MEM_D=0, MEM_BEn=2'b11, wait counter=0.
- Bus side advances only on CLK edges with CE=1. Memory side (REQ/ACK, data capture) advances on every CLK edge.
- Cycle start: in IDLE, on a CE edge with BCYSTn=0 and RAM_CEn=0:
  - Latch A, DI, WEn and BEn.
  - Set the lo-needed flag = (BEn[1:0]!=2'b11) and the hi-needed flag = (BEn[3:2]!=2'b11).
- States:
  - IDLE: wait for a cycle start.
  - LO: transfer the low half. MEM_A={A[ADDR_W-1:2],1'b0}, MEM_D=DI[15:0], MEM_BEn=BEn[1:0].
  - HI: transfer the high half. MEM_A={A[ADDR_W-1:2],1'b1}, MEM_D=DI[31:16], MEM_BEn=BEn[3:2].
  - WAIT: count WAIT_CE CE edges.
  - DONE: drive RAM_READYn=0.
- Transitions:
  - IDLE goes to LO if lo-needed, else HI if hi-needed, else WAIT.
  - LO goes to HI or WAIT on ACK.
  - HI goes to WAIT on ACK.
  - WAIT goes to DONE after WAIT_CE CE edges; with WAIT_CE=0 it passes straight through, taking zero cycles.
  - DONE returns to IDLE on the next CE edge, where the CPU samples ready.
- MEM_REQ:
  - Rises on the CLK edge that enters LO or HI.
  - Held, with address, data and byte enables stable, until the ACK cycle.
  - Drops on the edge after ACK, except LO->HI, where REQ stays high and A/D/BEn switch to the high half on that same edge.
- MEM_WE = ~WEn while REQ=1; 0 otherwise.
- Read data:
  - On ACK in LO, RAM_DO[15:0] <= MEM_Q. On ACK in HI, RAM_DO[31:16] <= MEM_Q.
  - Skipped halves keep their previous RAM_DO value.
  - RAM_DO holds between cycles.
- RAM_READYn = 0 only in DONE; 1 in every other state.
- Minimum latency with WAIT_CE=0 and ACK on the first REQ cycle, measured CLK edges from the start edge to RAM_READYn=0:
  - 2 for a single half.
  - 3 for both halves.
  - 1 when no bytes are enabled.
- Boundaries:
  - MEM_ACK while MEM_REQ=0: ignored.
  - BCYSTn=0 while not IDLE: ignored; no queuing.
  - RAM_CEn=1 at start: no cycle.
  - RAM_CEn rising mid-cycle: the outstanding half still completes (the handshake is never abandoned), remaining halves are skipped, return to IDLE without asserting RAM_READYn.
  - ACK arriving on the same edge as CE: the state moves once. The memory-side transition takes priority, and the CE-qualified DONE->IDLE transition is evaluated on the next CE.
  - RES mid-transaction: everything returns to reset values immediately. The memory controller must tolerate REQ dropping before ACK.

Decomposition:
- Package mach_pkg holds:
  - The state enum (IDLE, LO, HI, WAIT, DONE).
  - The RW encoding constants (RW_READ=1, RW_WRITE=0).
- No sub-module is needed: one FSM with latches and a 4-bit wait counter.

Test Plan:
- Read, BEn=0000, A=0x000104, memory returns 0x1111 at word 0x82 and 0x2222 at word 0x83, ACK one cycle after REQ -> two REQs with MEM_A 0x82 then 0x83; RAM_DO=0x22221111; RAM_READYn low for one CE.
- Write, BEn=1100, DI=0xAABBCCDD, A=0x000010 -> exactly one REQ: MEM_A=0x08, MEM_D=0xCCDD, MEM_BEn=00, MEM_WE=1; no high-half REQ; RAM_READYn asserts.
- Write, BEn=0011 -> only the high half: MEM_A odd, MEM_D=DI[31:16], MEM_BEn=00. BEn=1111 -> no REQ; RAM_READYn low on the next CE edge.
- ACK delayed 5 CLKs, CE every 2nd CLK, WAIT_CE=2 -> REQ and address stable throughout; RAM_READYn is asserted 2 CE edges after the final ACK and held until the sampling CE.
- RES pulse while REQ=1 in HI -> REQ=0, RAM_READYn=1, RAM_DO=0 immediately; a late ACK is ignored; the next cycle behaves normally.
- RAM_CEn deasserted during LO with both halves enabled -> the low half completes on ACK; no high-half REQ; RAM_READYn stays 1; the FSM returns to IDLE.

Source files
------------

// File: rtl/mach_pkg.sv
// Shared definitions for the V810 RAM-bus to 16-bit memory bridge.
//   state_t  : bridge FSM states
//   RW_READ / RW_WRITE : encoding of the bus RW (RAM_WEn) line
package mach_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,   // waiting for a bus cycle start
      ST_LO   = 3'd1,   // low 16-bit half in flight on the memory port
      ST_HI   = 3'd2,   // high 16-bit half in flight on the memory port
      ST_WAIT = 3'd3,   // optional extra CE cycles before ready
      ST_DONE = 3'd4    // RAM_READYn asserted until the CPU samples it
   } state_t;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mach_ram_bridge.sv
// Bridge between the 32-bit V810 RAM bus and a 16-bit request/acknowledge
// memory port. Each bus cycle becomes one or two 16-bit transfers; halves with
// no enabled bytes are skipped. Read data is assembled into RAM_DO and the bus
// cycle is closed with RAM_READYn.
//
// Ports
//   CLK, RES      clock, asynchronous active-high reset
//   CE            CPU clock enable; qualifies every bus-side decision
//   BCYSTn        bus cycle start (active low)
//   RAM_A/DI/DO   byte address, write data, read data (32-bit)
//   RAM_CEn       RAM select (active low)
//   RAM_WEn       RW: 1 = read, 0 = write
//   RAM_BEn       byte enables (active low)
//   RAM_READYn    cycle complete (active low)
//   MEM_A         16-bit word address
//   MEM_D/MEM_Q   write / read data of the memory port
//   MEM_BEn       byte enables (active low)
//   MEM_WE        1 = write, only while MEM_REQ is high
//   MEM_REQ       level request, held until the acknowledge cycle
//   MEM_ACK       one-clock acknowledge pulse
module mach_ram_bridge
   import mach_pkg::*;
#(
   parameter int ADDR_W  = 21,
   parameter int WAIT_CE = 0
) (
   input  logic              CLK,
   input  logic              RES,
   input  logic              CE,
   input  logic              BCYSTn,
   input  logic [ADDR_W-1:0] RAM_A,
   input  logic [31:0]       RAM_DI,
   output logic [31:0]       RAM_DO,
   input  logic              RAM_CEn,
   input  logic              RAM_WEn,
   input  logic [3:0]        RAM_BEn,
   output logic              RAM_READYn,
   output logic [ADDR_W-2:0] MEM_A,
   output logic [15:0]       MEM_D,
   input  logic [15:0]       MEM_Q,
   output logic [1:0]        MEM_BEn,
   output logic              MEM_WE,
   output logic              MEM_REQ,
   input  logic              MEM_ACK
);

   // Where a finished transfer goes: with no extra wait cycles WAIT is
   // bypassed entirely so it costs no clock.
   localparam state_t     POST_XFER = (WAIT_CE == 0) ? ST_DONE : ST_WAIT;
   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CE - 1);

   state_t            state_q,    state_d;
   logic [ADDR_W-3:0] word_a_q,   word_a_d;    // RAM_A[ADDR_W-1:2]
   logic [15:0]       hi_d_q,     hi_d_d;      // DI[31:16] for the high half
   logic [1:0]        hi_ben_q,   hi_ben_d;
   logic              hi_need_q,  hi_need_d;
   logic              we_q,       we_d;
   logic              abort_q,    abort_d;     // RAM_CEn went high mid-cycle
   logic [3:0]        wait_cnt_q, wait_cnt_d;
   logic [31:0]       ram_do_q,   ram_do_d;
   logic              ready_n_q,  ready_n_d;
   logic [ADDR_W-2:0] mem_a_q,    mem_a_d;
   logic [15:0]       mem_d_q,    mem_d_d;
   logic [1:0]        mem_ben_q,  mem_ben_d;
   logic              mem_req_q,  mem_req_d;
   logic              abort_now;
   logic [1:0]        unused_addr_lsb;

   // The memory port is 16 bits wide; the byte lane within a word is
   // expressed through the byte enables, so A[1:0] carries no information.
   assign unused_addr_lsb = RAM_A[1:0];

   always_comb begin
      state_d    = state_q;
      word_a_d   = word_a_q;
      hi_d_d     = hi_d_q;
      hi_ben_d   = hi_ben_q;
      hi_need_d  = hi_need_q;
      we_d       = we_q;
      abort_d    = abort_q;
      wait_cnt_d = wait_cnt_q;
      ram_do_d   = ram_do_q;
      mem_a_d    = mem_a_q;
      mem_d_d    = mem_d_q;
      mem_ben_d  = mem_ben_q;
      mem_req_d  = mem_req_q;

      // A deselect seen on this CE edge counts immediately, so a half that
      // completes on the same edge is already treated as the last one.
      abort_now = abort_q | (CE & RAM_CEn);
      if ((state_q != ST_IDLE) && CE && RAM_CEn) begin
         abort_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (CE && !BCYSTn && !RAM_CEn) begin
               word_a_d   = RAM_A[ADDR_W-1:2];
               hi_d_d     = RAM_DI[31:16];
               hi_ben_d   = RAM_BEn[3:2];
               hi_need_d  = (RAM_BEn[3:2] != 2'b11);
               abort_d    = 1'b0;
               wait_cnt_d = 4'd0;
               case (RAM_WEn)
                  RW_READ:  we_d = 1'b0;
                  RW_WRITE: we_d = 1'b1;
               endcase
               if (RAM_BEn[1:0] != 2'b11) begin
                  state_d   = ST_LO;
                  mem_req_d = 1'b1;
                  mem_a_d   = {RAM_A[ADDR_W-1:2], 1'b0};
                  mem_d_d   = RAM_DI[15:0];
                  mem_ben_d = RAM_BEn[1:0];
               end else if (RAM_BEn[3:2] != 2'b11) begin
                  state_d   = ST_HI;
                  mem_req_d = 1'b1;
                  mem_a_d   = {RAM_A[ADDR_W-1:2], 1'b1};
                  mem_d_d   = RAM_DI[31:16];
                  mem_ben_d = RAM_BEn[3:2];
               end else begin
                  state_d = POST_XFER;
               end
            end
         end

         ST_LO: begin
            if (MEM_ACK) begin
               ram_do_d[15:0] = MEM_Q;
               if (hi_need_q && !abort_now) begin
                  // REQ stays high; the port switches to the high half.
                  state_d   = ST_HI;
                  mem_a_d   = {word_a_q, 1'b1};
                  mem_d_d   = hi_d_q;
                  mem_ben_d = hi_ben_q;
               end else begin
                  mem_req_d = 1'b0;
                  state_d   = abort_now ? ST_IDLE : POST_XFER;
               end
            end
         end

         ST_HI: begin
            if (MEM_ACK) begin
               ram_do_d[31:16] = MEM_Q;
               mem_req_d       = 1'b0;
               state_d         = abort_now ? ST_IDLE : POST_XFER;
            end
         end

         ST_WAIT: begin
            if (CE) begin
               if (abort_now) begin
                  state_d = ST_IDLE;
               end else if (wait_cnt_q == WAIT_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  wait_cnt_d = wait_cnt_q + 4'd1;
               end
            end
         end

         ST_DONE: begin
            if (CE) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // Ready is registered from the next state so the bus sees a clean level.
   assign ready_n_d = (state_d != ST_DONE);

   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         state_q    <= ST_IDLE;
         word_a_q   <= '0;
         hi_d_q     <= '0;
         hi_ben_q   <= 2'b11;
         hi_need_q  <= 1'b0;
         we_q       <= 1'b0;
         abort_q    <= 1'b0;
         wait_cnt_q <= 4'd0;
         ram_do_q   <= '0;
         ready_n_q  <= 1'b1;
         mem_a_q    <= '0;
         mem_d_q    <= '0;
         mem_ben_q  <= 2'b11;
         mem_req_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_a_q   <= word_a_d;
         hi_d_q     <= hi_d_d;
         hi_ben_q   <= hi_ben_d;
         hi_need_q  <= hi_need_d;
         we_q       <= we_d;
         abort_q    <= abort_d;
         wait_cnt_q <= wait_cnt_d;
         ram_do_q   <= ram_do_d;
         ready_n_q  <= ready_n_d;
         mem_a_q    <= mem_a_d;
         mem_d_q    <= mem_d_d;
         mem_ben_q  <= mem_ben_d;
         mem_req_q  <= mem_req_d;
      end
   end

   assign RAM_DO     = ram_do_q;
   assign RAM_READYn = ready_n_q;
   assign MEM_A      = mem_a_q;
   assign MEM_D      = mem_d_q;
   assign MEM_BEn    = mem_ben_q;
   assign MEM_REQ    = mem_req_q;
   assign MEM_WE     = mem_req_q & we_q;

endmodule

// File: tb/tb_mach_ram_bridge.sv
// Directed bench for mach_ram_bridge. Instance 0 has no extra wait cycles,
// instance 1 uses WAIT_CE=2. Both share the bus inputs; each has its own
// memory responder with a programmable acknowledge delay.
module tb_mach_ram_bridge;
   import mach_pkg::*;

   logic        clk;
   logic        res;
   logic        ce;
   logic        ce_div;
   logic        bcyst_n;
   logic [20:0] ram_a;
   logic [31:0] ram_di;
   logic        ram_ce_n;
   logic        ram_we_n;
   logic [3:0]  ram_be_n;
   logic        ack_inj;

   logic [31:0] ram_do     [2];
   logic        ready_n    [2];
   logic [19:0] mem_a      [2];
   logic [15:0] mem_d      [2];
   logic [15:0] mem_q      [2];
   logic [1:0]  mem_ben    [2];
   logic        mem_we     [2];
   logic        mem_req    [2];
   logic        mem_ack    [2];
   logic        ack_to_dut [2];

   // memory model / monitors (written only by the responder process)
   logic [15:0] mem_img [256];
   int          ack_dly;
   int          dly_cnt [2]       = '{0, 0};
   int          txn_cnt [2]       = '{0, 0};
   int          stable_err [2]    = '{0, 0};
   int          ready_low_cnt [2] = '{0, 0};
   int          csa [2]           = '{0, 0};   // CE edges since last ACK
   logic        prev_req [2]      = '{1'b0, 1'b0};
   logic        prev_ack [2]      = '{1'b0, 1'b0};
   logic [38:0] prev_bus [2];
   logic [19:0] log_a   [2][16];
   logic [15:0] log_d   [2][16];
   logic [1:0]  log_ben [2][16];
   logic        log_we  [2][16];

   int tests_run    = 0;
   int tests_failed = 0;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dut
         mach_ram_bridge #(.ADDR_W(21), .WAIT_CE(gi * 2)) u_dut (
            .CLK        (clk),
            .RES        (res),
            .CE         (ce),
            .BCYSTn     (bcyst_n),
            .RAM_A      (ram_a),
            .RAM_DI     (ram_di),
            .RAM_DO     (ram_do[gi]),
            .RAM_CEn    (ram_ce_n),
            .RAM_WEn    (ram_we_n),
            .RAM_BEn    (ram_be_n),
            .RAM_READYn (ready_n[gi]),
            .MEM_A      (mem_a[gi]),
            .MEM_D      (mem_d[gi]),
            .MEM_Q      (mem_q[gi]),
            .MEM_BEn    (mem_ben[gi]),
            .MEM_WE     (mem_we[gi]),
            .MEM_REQ    (mem_req[gi]),
            .MEM_ACK    (ack_to_dut[gi])
         );
         assign ack_to_dut[gi] = mem_ack[gi] | ack_inj;
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory responder + monitors
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         mem_ack[i] <= 1'b0;
         if (mem_req[i] && prev_req[i] && !prev_ack[i] &&
             ({mem_a[i], mem_d[i], mem_ben[i], mem_we[i]} != prev_bus[i]))
            stable_err[i] <= stable_err[i] + 1;
         prev_req[i] <= mem_req[i];
         prev_ack[i] <= ack_to_dut[i];
         prev_bus[i] <= {mem_a[i], mem_d[i], mem_ben[i], mem_we[i]};
         if (mem_req[i] && !mem_ack[i]) begin
            if (dly_cnt[i] == ack_dly) begin
               mem_ack[i] <= 1'b1;
               mem_q[i]   <= mem_img[mem_a[i][7:0]];
               log_a[i][txn_cnt[i] % 16]   <= mem_a[i];
               log_d[i][txn_cnt[i] % 16]   <= mem_d[i];
               log_ben[i][txn_cnt[i] % 16] <= mem_ben[i];
               log_we[i][txn_cnt[i] % 16]  <= mem_we[i];
               txn_cnt[i] <= txn_cnt[i] + 1;
               dly_cnt[i] <= 0;
               $display("[TB] dut%0d mem txn a=0x%05h we=%0d d=0x%04h ben=%b q=0x%04h",
                        i, mem_a[i], mem_we[i], mem_d[i], mem_ben[i], mem_img[mem_a[i][7:0]]);
            end else begin
               dly_cnt[i] <= dly_cnt[i] + 1;
            end
         end else begin
            dly_cnt[i] <= 0;
         end
         if (!ready_n[i]) ready_low_cnt[i] <= ready_low_cnt[i] + 1;
         if (ack_to_dut[i]) csa[i] <= 0;
         else if (ce)       csa[i] <= csa[i] + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One clock; outputs are sampled and inputs driven 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (ce_div) ce = ~ce;
      else        ce = 1'b1;
   endtask

   task automatic pulse_reset();
      res = 1'b1;
      tick();
      tick();
      res = 1'b0;
      tick();
   endtask

   // Start a bus cycle and wait until the selected instance asserts ready.
   // lat = clock edges from the start edge to the edge that asserts ready.
   task automatic run_cycle(input int sel, input logic wen, input logic [3:0] be,
                            input logic [20:0] a, input logic [31:0] di, output int lat);
      logic s;
      bit   started;
      int   n;
      bcyst_n  = 1'b0;
      ram_ce_n = 1'b0;
      ram_we_n = wen;
      ram_be_n = be;
      ram_a    = a;
      ram_di   = di;
      started  = 0;
      n        = 0;
      while (!started && n < 20) begin
         s = ce;
         tick();
         n++;
         if (s) started = 1;
      end
      bcyst_n = 1'b1;
      if (!started) check("start_timeout", 32'd0, 32'd1);
      lat = 1;
      while (ready_n[sel] && lat < 200) begin
         tick();
         lat++;
      end
      if (ready_n[sel]) check("ready_timeout", 32'(ready_n[sel]), 32'd0);
      $display("[TB] dut%0d bus cycle we_n=%0d be_n=%b a=0x%06h di=0x%08h -> do=0x%08h lat=%0d",
               sel, wen, be, a, di, ram_do[sel], lat);
   endtask

   initial begin
      int lat;
      int base;
      int rbase;
      int n;

      for (int i = 0; i < 256; i++) mem_img[i] = 16'(i * 16'h0101);
      mem_img[8'h82] = 16'h1111;
      mem_img[8'h83] = 16'h2222;
      mem_img[8'h84] = 16'h3333;
      mem_img[8'h85] = 16'h4444;

      res = 1'b0; ce = 1'b1; ce_div = 1'b0; bcyst_n = 1'b1;
      ram_a = '0; ram_di = '0; ram_ce_n = 1'b1; ram_we_n = RW_READ;
      ram_be_n = 4'b1111; ack_inj = 1'b0; ack_dly = 0;

      // ---- reset values
      #3 res = 1'b1;
      tick();
      tick();
      check("rst_do",   ram_do[0],  32'h0);
      check("rst_rdy",  32'(ready_n[0]), 32'd1);
      check("rst_req",  32'(mem_req[0]), 32'd0);
      check("rst_we",   32'(mem_we[0]),  32'd0);
      check("rst_a",    32'(mem_a[0]),   32'd0);
      check("rst_d",    32'(mem_d[0]),   32'd0);
      check("rst_ben",  32'(mem_ben[0]), 32'd3);
      res = 1'b0;
      tick();

      // ---- read, both halves
      base = txn_cnt[0];
      run_cycle(0, RW_READ, 4'b0000, 21'h000104, 32'h0, lat);
      check("rd2_lat",  lat, 5);
      check("rd2_do",   ram_do[0], 32'h22221111);
      check("rd2_ntxn", txn_cnt[0] - base, 2);
      check("rd2_a0",   32'(log_a[0][base % 16]), 32'h82);
      check("rd2_a1",   32'(log_a[0][(base + 1) % 16]), 32'h83);
      check("rd2_we",   32'(log_we[0][base % 16]), 32'd0);
      tick();
      check("rd2_rdy_one_ce", 32'(ready_n[0]), 32'd1);

      // ---- read, high half only: low half of RAM_DO is kept
      base = txn_cnt[0];
      run_cycle(0, RW_READ, 4'b0011, 21'h000108, 32'h0, lat);
      check("rdhi_lat",  lat, 3);
      check("rdhi_ntxn", txn_cnt[0] - base, 1);
      check("rdhi_a",    32'(log_a[0][base % 16]), 32'h85);
      check("rdhi_do",   ram_do[0], 32'h44441111);
      tick();

      // ---- write, low half only
      base = txn_cnt[0];
      run_cycle(0, RW_WRITE, 4'b1100, 21'h000010, 32'hAABBCCDD, lat);
      check("wrlo_lat",  lat, 3);
      check("wrlo_ntxn", txn_cnt[0] - base, 1);
      check("wrlo_a",    32'(log_a[0][base % 16]), 32'h08);
      check("wrlo_d",    32'(log_d[0][base % 16]), 32'hCCDD);
      check("wrlo_ben",  32'(log_ben[0][base % 16]), 32'd0);
      check("wrlo_we",   32'(log_we[0][base % 16]), 32'd1);
      tick();
      check("wrlo_req_low", 32'(mem_req[0]), 32'd0);

      // ---- write, high half only
      base = txn_cnt[0];
      run_cycle(0, RW_WRITE, 4'b0011, 21'h000020, 32'h12345678, lat);
      check("wrhi_lat",  lat, 3);
      check("wrhi_ntxn", txn_cnt[0] - base, 1);
      check("wrhi_a",    32'(log_a[0][base % 16]), 32'h11);
      check("wrhi_d",    32'(log_d[0][base % 16]), 32'h1234);
      check("wrhi_ben",  32'(log_ben[0][base % 16]), 32'd0);
      tick();

      // ---- write, partial enables in both halves
      base = txn_cnt[0];
      run_cycle(0, RW_WRITE, 4'b1001, 21'h000040, 32'h11223344, lat);
      check("wrpt_lat",  lat, 5);
      check("wrpt_ntxn", txn_cnt[0] - base, 2);
      check("wrpt_a0",   32'(log_a[0][base % 16]), 32'h20);
      check("wrpt_d0",   32'(log_d[0][base % 16]), 32'h3344);
      check("wrpt_ben0", 32'(log_ben[0][base % 16]), 32'd1);
      check("wrpt_a1",   32'(log_a[0][(base + 1) % 16]), 32'h21);
      check("wrpt_d1",   32'(log_d[0][(base + 1) % 16]), 32'h1122);
      check("wrpt_ben1", 32'(log_ben[0][(base + 1) % 16]), 32'd2);
      tick();

      // ---- no bytes enabled
      base = txn_cnt[0];
      run_cycle(0, RW_WRITE, 4'b1111, 21'h000030, 32'h0, lat);
      check("none_lat",  lat, 1);
      check("none_ntxn", txn_cnt[0] - base, 0);
      tick();
      check("none_rdy_rel", 32'(ready_n[0]), 32'd1);

      // ---- WAIT_CE=2 instance, slow ACK, CE every second clock
      pulse_reset();
      ack_dly = 5;
      ce_div  = 1'b1;
      base    = txn_cnt[1];
      rbase   = stable_err[1];
      run_cycle(1, RW_READ, 4'b0000, 21'h000104, 32'h0, lat);
      check("wce_ce_after_ack", csa[1], 2);
      check("wce_do",     ram_do[1], 32'h22221111);
      check("wce_ntxn",   txn_cnt[1] - base, 2);
      check("wce_a1",     32'(log_a[1][(base + 1) % 16]), 32'h83);
      check("wce_stable", stable_err[1] - rbase, 0);
      tick();
      check("wce_rdy_hold", 32'(ready_n[1]), 32'd0);
      tick();
      check("wce_rdy_rel",  32'(ready_n[1]), 32'd1);
      ce_div = 1'b0;
      ce     = 1'b1;

      // ---- reset while the high half is outstanding
      pulse_reset();
      ack_dly  = 3;
      bcyst_n  = 1'b0; ram_ce_n = 1'b0; ram_we_n = RW_READ;
      ram_be_n = 4'b0000; ram_a = 21'h000104;
      tick();
      bcyst_n = 1'b1;
      n = 0;
      while (!(mem_req[0] && mem_a[0] == 20'h83) && n < 40) begin
         tick();
         n++;
      end
      check("res_reach_hi", 32'(mem_req[0] && mem_a[0] == 20'h83), 32'd1);
      #2 res = 1'b1;
      #1;
      check("res_req",  32'(mem_req[0]), 32'd0);
      check("res_rdy",  32'(ready_n[0]), 32'd1);
      check("res_do",   ram_do[0], 32'h0);
      check("res_ben",  32'(mem_ben[0]), 32'd3);
      tick();
      res     = 1'b0;
      ack_inj = 1'b1;
      tick();
      ack_inj = 1'b0;
      tick();
      check("late_ack_req", 32'(mem_req[0]), 32'd0);
      check("late_ack_do",  ram_do[0], 32'h0);
      check("late_ack_rdy", 32'(ready_n[0]), 32'd1);
      ack_dly = 0;
      run_cycle(0, RW_READ, 4'b1100, 21'h000104, 32'h0, lat);
      check("post_res_lat", lat, 3);
      check("post_res_do",  ram_do[0], 32'h00001111);
      tick();

      // ---- RAM_CEn released during the low half
      pulse_reset();
      ack_dly  = 3;
      base     = txn_cnt[0];
      rbase    = ready_low_cnt[0];
      bcyst_n  = 1'b0; ram_ce_n = 1'b0; ram_we_n = RW_READ;
      ram_be_n = 4'b0000; ram_a = 21'h000108;
      tick();
      bcyst_n  = 1'b1;
      ram_ce_n = 1'b1;
      n = 0;
      while (txn_cnt[0] == base && n < 30) begin
         tick();
         n++;
      end
      for (int k = 0; k < 10; k++) tick();
      check("abort_ntxn", txn_cnt[0] - base, 1);
      check("abort_a",    32'(log_a[0][base % 16]), 32'h84);
      check("abort_rdy",  ready_low_cnt[0] - rbase, 0);
      check("abort_req",  32'(mem_req[0]), 32'd0);
      check("abort_do",   ram_do[0], 32'h00003333);
      ack_dly = 0;
      run_cycle(0, RW_READ, 4'b1111, 21'h000108, 32'h0, lat);
      check("abort_idle_lat", lat, 1);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
